// File: rtl/fetch_decode_unit_if.sv
// Bundle of fetch/decode unit signals shared between the unit (master) and
// the instruction memory / register file / ALU side (slave).
`default_nettype none

interface fetch_decode_unit_if;
  logic [15:0] PC_out;
  logic [15:0] IMEM_addr;
  logic        IMEM_req;
  logic        IMEM_ready;
  logic [31:0] IMEM_data;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        stall;
  logic [3:0]  IR_ARn;
  logic [3:0]  IR_ARs;
  logic [3:0]  IR_ARm;
  logic [3:0]  IR_ARd;
  logic [7:0]  IR_opcode;
  logic [15:0] IR_imm;
  logic        CNTRL_write_en_ARd;
  logic [15:0] PC_next;
  logic        fault;

  modport master (
    input  PC_out, IMEM_ready, IMEM_data, branch_taken, branch_target, stall,
    output IMEM_addr, IMEM_req, IR_ARn, IR_ARs, IR_ARm, IR_ARd, IR_opcode,
           IR_imm, CNTRL_write_en_ARd, PC_next, fault
  );

  modport slave (
    output PC_out, IMEM_ready, IMEM_data, branch_taken, branch_target, stall,
    input  IMEM_addr, IMEM_req, IR_ARn, IR_ARs, IR_ARm, IR_ARd, IR_opcode,
           IR_imm, CNTRL_write_en_ARd, PC_next, fault
  );
endinterface

`default_nettype wire

// File: rtl/fetch_decode_unit.sv
// Fetch/decode/execute sequencer: fetches a 32-bit instruction, exposes its
// register fields, waits out ALU stalls and computes the next PC.
`default_nettype none

module fetch_decode_unit #(
  parameter int FETCH_TIMEOUT = 15
) (
  input  wire logic             CLOCK_50,
  input  wire logic             RESET_N,
  fetch_decode_unit_if.master   bus
);

  localparam int CNT_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [31:0]      ir;
  logic [CNT_W-1:0] fetch_cnt;
  logic             br_taken_q;
  logic [15:0]      br_target_q;
  logic             fault_q;
  logic             accept;
  logic             timeout_hit;

  assign accept      = (state == S_FETCH) && bus.IMEM_ready;
  // A ready strobe in the last allowed cycle still counts as a successful fetch
  assign timeout_hit = (state == S_FETCH) && !bus.IMEM_ready && (fetch_cnt == CNT_LAST);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      state_next = S_FETCH;
      S_FETCH: begin
        if (accept)
          state_next = S_DECODE;
        else if (timeout_hit)
          state_next = S_FAULT;
      end
      S_DECODE:    state_next = (ir[31:24] == 8'hFF) ? S_HALT : S_EXECUTE;
      S_EXECUTE:   state_next = bus.stall ? S_EXECUTE : S_WRITEBACK;
      S_WRITEBACK: state_next = S_FETCH;
      S_HALT:      state_next = S_HALT;
      S_FAULT:     state_next = S_FAULT;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= S_IDLE;
      ir          <= 32'h0;
      fetch_cnt   <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= 16'h0;
      fault_q     <= 1'b0;
    end else begin
      state <= state_next;
      if (accept)
        ir <= bus.IMEM_data;
      // Counter is zero whenever FETCH is entered since it only runs inside FETCH
      if ((state == S_FETCH) && !bus.IMEM_ready)
        fetch_cnt <= fetch_cnt + CNT_W'(1);
      else
        fetch_cnt <= '0;
      if ((state == S_EXECUTE) && !bus.stall) begin
        br_taken_q  <= bus.branch_taken;
        br_target_q <= bus.branch_target;
      end
      if (timeout_hit)
        fault_q <= 1'b1;
    end
  end

  assign bus.IMEM_addr = bus.PC_out;
  assign bus.IMEM_req  = (state == S_FETCH);
  assign bus.IR_opcode = ir[31:24];
  assign bus.IR_ARd    = ir[23:20];
  assign bus.IR_ARn    = ir[19:16];
  assign bus.IR_ARs    = ir[15:12];
  assign bus.IR_ARm    = ir[11:8];
  assign bus.IR_imm    = ir[15:0];
  assign bus.fault     = fault_q;

  // Only ALU (00) and load (01) classes write the destination register
  assign bus.CNTRL_write_en_ARd = (state == S_WRITEBACK) && !ir[31];

  always_comb begin
    bus.PC_next = bus.PC_out;
    if (state == S_WRITEBACK) begin
      if (br_taken_q && (ir[31:30] == 2'b11))
        bus.PC_next = br_target_q;
      else
        bus.PC_next = bus.PC_out + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_decode_unit.sv
// Directed self-checking bench for fetch_decode_unit.
`default_nettype none

module tb_fetch_decode_unit;

  logic CLOCK_50;
  logic RESET_N;
  int   checks;
  int   errors;

  fetch_decode_unit_if bus();

  fetch_decode_unit #(.FETCH_TIMEOUT(15)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .bus      (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts in FETCH with an immediate ready, ends back in FETCH
  task automatic run_instr(input string tag, input logic [15:0] pc, input logic [31:0] data,
                           input logic exp_we, input logic [15:0] exp_pc);
    bus.PC_out     = pc;
    bus.IMEM_data  = data;
    bus.IMEM_ready = 1'b1;
    step();
    bus.IMEM_ready = 1'b0;
    step();
    step();
    chk({tag, "_we"}, {31'h0, bus.CNTRL_write_en_ARd}, {31'h0, exp_we});
    chk({tag, "_pcnext"}, {16'h0, bus.PC_next}, {16'h0, exp_pc});
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RESET_N           = 1'b0;
    bus.PC_out        = 16'h0;
    bus.IMEM_ready    = 1'b0;
    bus.IMEM_data     = 32'h0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 16'h0;
    bus.stall         = 1'b0;
    #12;
    chk("rst_req", {31'h0, bus.IMEM_req}, 32'h0);
    chk("rst_we", {31'h0, bus.CNTRL_write_en_ARd}, 32'h0);
    chk("rst_fault", {31'h0, bus.fault}, 32'h0);
    chk("rst_opcode", {24'h0, bus.IR_opcode}, 32'h0);
    chk("rst_pcnext", {16'h0, bus.PC_next}, 32'h0);
    chk("rst_addr", {16'h0, bus.IMEM_addr}, 32'h0);

    step();
    RESET_N = 1'b1;
    step();
    chk("fetch_req", {31'h0, bus.IMEM_req}, 32'h1);

    // ALU instruction with ready after two fetch cycles
    bus.IMEM_data = 32'h0073_4200;
    step();
    bus.IMEM_ready = 1'b1;
    step();
    bus.IMEM_ready = 1'b0;
    chk("alu_ARd", {28'h0, bus.IR_ARd}, 32'd7);
    chk("alu_ARn", {28'h0, bus.IR_ARn}, 32'd3);
    chk("alu_ARs", {28'h0, bus.IR_ARs}, 32'd4);
    chk("alu_ARm", {28'h0, bus.IR_ARm}, 32'd2);
    chk("alu_imm", {16'h0, bus.IR_imm}, 32'h4200);
    chk("dec_req", {31'h0, bus.IMEM_req}, 32'h0);
    chk("dec_we", {31'h0, bus.CNTRL_write_en_ARd}, 32'h0);
    bus.IMEM_data  = 32'hDEAD_BEEF;
    bus.IMEM_ready = 1'b1;
    step();
    bus.IMEM_ready = 1'b0;
    chk("ir_hold_opc", {24'h0, bus.IR_opcode}, 32'h0);
    chk("ir_hold_ARd", {28'h0, bus.IR_ARd}, 32'd7);
    chk("exe_we", {31'h0, bus.CNTRL_write_en_ARd}, 32'h0);
    chk("exe_pcnext", {16'h0, bus.PC_next}, 32'h0);
    step();
    chk("alu_wb_we", {31'h0, bus.CNTRL_write_en_ARd}, 32'h1);
    chk("alu_wb_pcnext", {16'h0, bus.PC_next}, 32'h1);
    step();
    chk("alu_after_we", {31'h0, bus.CNTRL_write_en_ARd}, 32'h0);
    chk("alu_after_req", {31'h0, bus.IMEM_req}, 32'h1);

    // Taken branch
    bus.PC_out     = 16'h0010;
    bus.IMEM_data  = 32'hC000_0040;
    bus.IMEM_ready = 1'b1;
    step();
    bus.IMEM_ready    = 1'b0;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0040;
    chk("br_opcode", {24'h0, bus.IR_opcode}, 32'hC0);
    step();
    step();
    chk("br_wb_we", {31'h0, bus.CNTRL_write_en_ARd}, 32'h0);
    chk("br_wb_pcnext", {16'h0, bus.PC_next}, 32'h0040);
    bus.branch_taken  = 1'b0;
    bus.branch_target = 16'h0;
    step();

    // PC wrap, with a stray branch_taken on an ALU opcode
    bus.PC_out     = 16'hFFFF;
    bus.IMEM_data  = 32'h0100_0000;
    bus.IMEM_ready = 1'b1;
    step();
    bus.IMEM_ready    = 1'b0;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h1234;
    step();
    step();
    chk("wrap_pcnext", {16'h0, bus.PC_next}, 32'h0000);
    chk("wrap_we", {31'h0, bus.CNTRL_write_en_ARd}, 32'h1);
    bus.branch_taken  = 1'b0;
    bus.branch_target = 16'h0;
    step();

    // Stall three cycles; branch inputs only matter in the release cycle
    bus.PC_out     = 16'h0005;
    bus.IMEM_data  = 32'hC200_0000;
    bus.IMEM_ready = 1'b1;
    step();
    bus.IMEM_ready    = 1'b0;
    bus.stall         = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'hAAAA;
    step();
    step();
    step();
    chk("stall_we", {31'h0, bus.CNTRL_write_en_ARd}, 32'h0);
    chk("stall_pcnext", {16'h0, bus.PC_next}, 32'h0005);
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 16'h0BEE;
    step();
    chk("stall_wb_pcnext", {16'h0, bus.PC_next}, 32'h0006);
    step();

    run_instr("load", 16'h0007, 32'h4050_0000, 1'b1, 16'h0008);
    run_instr("store", 16'h0008, 32'h8050_0000, 1'b0, 16'h0009);

    // HALT
    bus.PC_out     = 16'h0123;
    bus.IMEM_data  = 32'hFF00_0000;
    bus.IMEM_ready = 1'b1;
    step();
    bus.IMEM_ready = 1'b0;
    step();
    chk("halt_req", {31'h0, bus.IMEM_req}, 32'h0);
    chk("halt_we", {31'h0, bus.CNTRL_write_en_ARd}, 32'h0);
    chk("halt_pcnext", {16'h0, bus.PC_next}, 32'h0123);
    bus.IMEM_ready = 1'b1;
    step();
    step();
    chk("halt_stay_req", {31'h0, bus.IMEM_req}, 32'h0);
    chk("halt_stay_opc", {24'h0, bus.IR_opcode}, 32'hFF);
    bus.IMEM_ready = 1'b0;
    RESET_N = 1'b0;
    #2;
    chk("halt_rst_opc", {24'h0, bus.IR_opcode}, 32'h0);
    chk("halt_rst_req", {31'h0, bus.IMEM_req}, 32'h0);
    step();
    RESET_N    = 1'b1;
    bus.PC_out = 16'h0;

    // Ready in the last allowed fetch cycle beats the timeout
    step();
    for (int i = 0; i < 14; i++) step();
    bus.IMEM_data  = 32'h0020_0000;
    bus.IMEM_ready = 1'b1;
    step();
    bus.IMEM_ready = 1'b0;
    chk("edge_fault", {31'h0, bus.fault}, 32'h0);
    chk("edge_ARd", {28'h0, bus.IR_ARd}, 32'd2);
    chk("edge_req", {31'h0, bus.IMEM_req}, 32'h0);
    RESET_N = 1'b0;
    #2;
    step();
    RESET_N = 1'b1;
    step();

    // Timeout
    for (int i = 0; i < 14; i++) begin
      chk("to_wait_fault", {31'h0, bus.fault}, 32'h0);
      step();
    end
    chk("to_last_req", {31'h0, bus.IMEM_req}, 32'h1);
    chk("to_last_fault", {31'h0, bus.fault}, 32'h0);
    step();
    chk("to_fault", {31'h0, bus.fault}, 32'h1);
    chk("to_req", {31'h0, bus.IMEM_req}, 32'h0);
    bus.IMEM_ready = 1'b1;
    step();
    step();
    step();
    chk("to_sticky", {31'h0, bus.fault}, 32'h1);
    chk("to_sticky_req", {31'h0, bus.IMEM_req}, 32'h0);
    chk("to_sticky_opc", {24'h0, bus.IR_opcode}, 32'h0);
    bus.IMEM_ready = 1'b0;
    RESET_N = 1'b0;
    #2;
    chk("to_rst_fault", {31'h0, bus.fault}, 32'h0);
    step();
    RESET_N = 1'b1;
    step();

    // Reset in the middle of writeback kills the write enable at once
    bus.IMEM_data  = 32'h0010_0000;
    bus.IMEM_ready = 1'b1;
    step();
    bus.IMEM_ready = 1'b0;
    step();
    step();
    chk("wbrst_pre_we", {31'h0, bus.CNTRL_write_en_ARd}, 32'h1);
    RESET_N = 1'b0;
    #1;
    chk("wbrst_we", {31'h0, bus.CNTRL_write_en_ARd}, 32'h0);
    chk("wbrst_req", {31'h0, bus.IMEM_req}, 32'h0);
    chk("wbrst_pcnext", {16'h0, bus.PC_next}, 32'h0);
    step();
    RESET_N = 1'b1;
    step();
    chk("restart_req", {31'h0, bus.IMEM_req}, 32'h1);
    chk("restart_ARd", {28'h0, bus.IR_ARd}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
